ander_stream: RTL and testbench
===============================

# ander_stream

Parametrised, registered successor to the two-input AND gate. Folds a framed stream of WIDTH-bit words into one bitwise-AND result per frame, plus a reduction-AND flag. Sits between a word producer and a result consumer; both sides use valid/ready handshakes. Single clock, no combinational path from input to output.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- CNT_W, 8, beat-counter width in bits (≥1)

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset; one clock, synchronous and active-high
- in_valid  in  1  input word present
- in_ready  out  1  block accepts a word this cycle
- in_data  in  WIDTH  input word
- in_last  in  1  marks the final word of a frame
- out_valid  out  1  frame result present
- out_ready  in  1  consumer takes the result this cycle
- out_data  out  WIDTH  bitwise AND of all words in the frame
- out_all  out  1  &out_data (every bit set in every word)
- out_cnt  out  CNT_W  words in the frame, saturating (only with ANDER_CNT_EN)

## Operation
- Beat accepted when in_valid & in_ready; result taken when out_valid & out_ready.
- States: IDLE (no frame open), ACC (frame open), HOLD (result waiting).
- IDLE: in_ready=1. Accepted beat: acc ← in_data, cnt ← 1. Go to ACC, or to HOLD if in_last.
- ACC: in_ready=1. Accepted beat: acc ← acc & in_data, cnt ← cnt+1 (saturates at 2^CNT_W−1). Go to HOLD if in_last.
- On any transition into HOLD: out_data ← the final AND value, out_all ← its reduction AND, out_cnt ← the final count. All three are registered.
- HOLD: in_ready=0 and out_valid=1. Outputs stay stable until taken. When taken, go to IDLE.
- No bubble-free overlap: the first beat of the next frame is accepted one cycle after the result is taken at the earliest.
- in_last is ignored unless its beat is accepted. in_data is don't-care when in_valid=0.
- ACC with no accepted beat holds state indefinitely; there is no timeout.
- Reset in any state discards any open frame or pending result.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_all=0, out_cnt=0, internal acc=all ones.
- in_ready is a function of state only, so it is registered and has no combinational dependency on in_valid.
- Latency: a last beat accepted at edge N gives out_valid=1 from edge N to the edge at which it is taken.
- Throughput: one beat per cycle within a frame. Per frame, add 1 cycle beyond the HOLD cycles.
- out_valid is never withdrawn before it is taken.
- rst has priority over every handshake in the same cycle.

## Configuration
- ANDER_CNT_EN defined:
  - out_cnt port present.
  - Counter implemented; saturates at 2^CNT_W−1 and never wraps.
- ANDER_CNT_EN undefined:
  - out_cnt port and counter are removed.
  - All other behaviour and timing are identical.

## Test plan
- Reset, then idle 3 cycles:
  - in_ready=1, out_valid=0, out_data=0x00, out_all=0.
- WIDTH=8, frame 0xFF, 0xF3, 0x7E (last), out_ready=1:
  - out_data=0x72, out_all=0, out_cnt=3.
  - out_valid high for exactly 1 cycle, starting the cycle after the last beat is accepted.
- Single-beat frame 0xFF with in_last=1:
  - out_data=0xFF, out_all=1, out_cnt=1.
- Frame 0x0F, 0x3C (last) with out_ready=0 for 5 cycles, then 1:
  - out_data=0x0C stable throughout HOLD.
  - in_ready=0 throughout HOLD, and in_valid pulses in HOLD are not consumed.
  - Result taken on the 6th cycle.
- CNT_W=2, frame of 6 beats of 0xAA with ANDER_CNT_EN:
  - out_cnt=3 (saturated), out_data=0xAA.
- Assert rst for one cycle after 2 beats of an open frame, then send frame 0x81 (last):
  - out_data=0x81 and out_cnt=1; no trace of the aborted frame.

Source files
------------

// File: rtl/ander_stream.sv
// Framed bitwise-AND accumulator with valid/ready on both sides and registered outputs.
// Define ANDER_CNT_EN to add the saturating beat counter and the out_cnt port.
module ander_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_all
`ifdef ANDER_CNT_EN
  , output logic [CNT_W-1:0] out_cnt
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("ander_stream: WIDTH and CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_all_q, out_all_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] acc_new;
  logic             accept;
  logic             take;
`ifdef ANDER_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] cnt_new;
`endif

  assign accept = in_valid & in_ready_q;
  assign take   = out_valid_q & out_ready;

  // The first beat of a frame seeds the accumulator instead of ANDing into it.
  assign acc_new = (state_q == IDLE) ? in_data : (acc_q & in_data);
`ifdef ANDER_CNT_EN
  assign cnt_new = (state_q == IDLE) ? CNT_W'(1)
                 : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_all_d   = out_all_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef ANDER_CNT_EN
    cnt_d       = cnt_q;
    out_cnt_d   = out_cnt_q;
`endif
    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          acc_d = acc_new;
`ifdef ANDER_CNT_EN
          cnt_d = cnt_new;
`endif
          if (in_last) begin
            state_d     = HOLD;
            out_data_d  = acc_new;
            out_all_d   = &acc_new;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
`ifdef ANDER_CNT_EN
            out_cnt_d   = cnt_new;
`endif
          end else begin
            state_d = ACC;
          end
        end
      end
      HOLD: begin
        if (take) begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '1;
      out_data_q  <= '0;
      out_all_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ANDER_CNT_EN
      cnt_q       <= '0;
      out_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_all_q   <= out_all_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef ANDER_CNT_EN
      cnt_q       <= cnt_d;
      out_cnt_q   <= out_cnt_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_all   = out_all_q;
`ifdef ANDER_CNT_EN
  assign out_cnt   = out_cnt_q;
`endif

endmodule

// File: tb/tb_ander_stream.sv
// Bench for ander_stream: directed frames with literal expectations plus randomized
// traffic compared every cycle against a frame-level reference model.
module tb_ander_stream;
  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_all;
`ifdef ANDER_CNT_EN
  logic [CNT_W-1:0] out_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ander_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_all(out_all)
`ifdef ANDER_CNT_EN
    , .out_cnt(out_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a running AND plus a beat count; a finished frame
  // blocks input until the consumer takes it.
  bit             started = 0;
  bit             m_pending = 0;
  bit             m_open = 0;
  logic [WIDTH-1:0] m_acc = '1;
  int             m_n = 0;
  logic [WIDTH-1:0] m_data = '0;
  bit             m_all = 0;
  int             m_cnt = 0;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      m_pending = 0; m_open = 0; m_data = '0; m_all = 0; m_cnt = 0; m_n = 0;
    end else if (m_pending) begin
      if (out_ready) m_pending = 0;
    end else if (in_valid) begin
      m_acc = m_open ? (m_acc & in_data) : in_data;
      m_n   = m_open ? m_n + 1 : 1;
      if (in_last) begin
        m_pending = 1;
        m_open    = 0;
        m_data    = m_acc;
        m_all     = (m_acc == {WIDTH{1'b1}});
        m_cnt     = (m_n > MAXC) ? MAXC : m_n;
      end else begin
        m_open = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready",  {31'b0, in_ready},  {31'b0, !m_pending});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_pending});
      chk("out_data",  {24'b0, out_data},  {24'b0, m_data});
      chk("out_all",   {31'b0, out_all},   {31'b0, m_all});
`ifdef ANDER_CNT_EN
      chk("out_cnt",   {30'b0, out_cnt},   m_cnt);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic [WIDTH-1:0] d, input logic l);
    bit ok;
    bit rdy;
    ok = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = in_ready;
      step();
      if (rdy) begin ok = 1; break; end
    end
    in_valid = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL beat_accept timed out data %0h", d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data",  {24'b0, out_data},  32'h00);
    chk("rst_out_all",   {31'b0, out_all},   32'd0);

    out_ready = 1'b1;
    beat(8'hFF, 0); beat(8'hF3, 0); beat(8'h7E, 1);
    chk("f1_valid", {31'b0, out_valid}, 32'd1);
    chk("f1_data",  {24'b0, out_data},  32'h72);
    chk("f1_all",   {31'b0, out_all},   32'd0);
`ifdef ANDER_CNT_EN
    chk("f1_cnt",   {30'b0, out_cnt},   32'd3);
`endif
    step();
    chk("f1_one_cycle", {31'b0, out_valid}, 32'd0);

    beat(8'hFF, 1);
    chk("f2_data", {24'b0, out_data}, 32'hFF);
    chk("f2_all",  {31'b0, out_all},  32'd1);
`ifdef ANDER_CNT_EN
    chk("f2_cnt",  {30'b0, out_cnt},  32'd1);
`endif
    step();

    out_ready = 1'b0;
    beat(8'h0F, 0); beat(8'h3C, 1);
    for (int i = 0; i < 5; i++) begin
      chk("f3_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("f3_hold_data",  {24'b0, out_data},  32'h0C);
      chk("f3_hold_ready", {31'b0, in_ready},  32'd0);
      in_valid = 1'b1; in_data = 8'h00; in_last = 1'b1;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("f3_still_data", {24'b0, out_data}, 32'h0C);
    step();
    chk("f3_taken", {31'b0, out_valid}, 32'd0);

    for (int i = 0; i < 6; i++) beat(8'hAA, i == 5);
    chk("f4_data", {24'b0, out_data}, 32'hAA);
`ifdef ANDER_CNT_EN
    chk("f4_cnt_sat", {30'b0, out_cnt}, 32'd3);
`endif
    step();

    beat(8'h11, 0); beat(8'h22, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    beat(8'h81, 1);
    chk("f5_data", {24'b0, out_data}, 32'h81);
    chk("f5_all",  {31'b0, out_all},  32'd0);
`ifdef ANDER_CNT_EN
    chk("f5_cnt",  {30'b0, out_cnt},  32'd1);
`endif
    step();

    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = WIDTH'($urandom | $urandom | $urandom);
      in_last   = ($urandom_range(3) == 0);
      out_ready = ($urandom_range(2) != 0);
      rst       = ($urandom_range(149) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
